// File: rtl/aes_128_pkg.sv
// ---------------------------------------------------------------------------
// aes_128_pkg
// Shared AES-128 definitions for the encrypt and decrypt blocks:
//   SBOX / INV_SBOX : byte substitution tables
//   RCON            : round constants, indexed by round number 1..10
//   aes_state_e     : FSM state encoding of the iterative cores
//   xtime / gf_mul  : GF(2^8) arithmetic (polynomial x^8+x^4+x^3+x+1)
//   key_fwd/key_inv : one forward / inverse AES-128 key-schedule step
// ---------------------------------------------------------------------------
package aes_128_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        ARK0  = 3'd2,
        ROUND = 3'd3,
        FINAL = 3'd4
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Indexed directly by the 4-bit round counter; only entries 1..10 are
    // real round constants, the rest are zero so any counter value is legal.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        // RotWord then SubWord: {b1,b2,b3,b0} through the S-box
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo key_fwd: recover w3..w1 first, then w0 needs the recovered w3.
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_128_dec_if.sv
// ---------------------------------------------------------------------------
// aes_128_dec_if
// Request/response bundle of the AES-128 decryptor.
//   in_valid/in_ready : start handshake, in_bus = ciphertext, key = cipher key
//   out_bus/out_valid : registered plaintext with a one-cycle valid pulse
// master = requester (drives the block), slave = the decryptor.
// ---------------------------------------------------------------------------
interface aes_128_dec_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_bus;
    logic [127:0] key;
    logic [127:0] out_bus;
    logic         out_valid;

    modport master (
        output in_valid, in_bus, key,
        input  in_ready, out_bus, out_valid
    );

    modport slave (
        input  in_valid, in_bus, key,
        output in_ready, out_bus, out_valid
    );
endinterface

// File: rtl/aes_128_inv_round.sv
// ---------------------------------------------------------------------------
// aes_128_inv_round
// Combinational AES inverse round:
//   state_out = [InvMixColumns]( InvSubBytes(InvShiftRows(state_in)) ^ round_key )
// Ports:
//   state_in   : 128-bit state, byte 0 = [127:120], column-major
//   round_key  : round key added after the substitution
//   last_round : 1 skips InvMixColumns (final round)
//   state_out  : resulting state
// ---------------------------------------------------------------------------
module aes_128_inv_round
    import aes_128_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);

    // Element 0 of a [0:15] packed array sits in the MSBs, i.e. byte 0.
    typedef logic [0:15][7:0] blk_t;

    blk_t s;
    blk_t t;
    blk_t m;

    always_comb begin
        s = state_in;
        // InvShiftRows: row r rotates right by r columns
        t = {s[0], s[13], s[10], s[7],
             s[4], s[1],  s[14], s[11],
             s[8], s[5],  s[2],  s[15],
             s[12], s[9], s[6],  s[3]};
        for (int i = 0; i < 16; i++) begin
            t[i] = INV_SBOX[t[i]];
        end
        t = t ^ blk_t'(round_key);
        m = t;
        if (!last_round) begin
            for (int c = 0; c < 4; c++) begin
                m[4*c+0] = gf_mul(t[4*c], 8'h0e) ^ gf_mul(t[4*c+1], 8'h0b)
                         ^ gf_mul(t[4*c+2], 8'h0d) ^ gf_mul(t[4*c+3], 8'h09);
                m[4*c+1] = gf_mul(t[4*c], 8'h09) ^ gf_mul(t[4*c+1], 8'h0e)
                         ^ gf_mul(t[4*c+2], 8'h0b) ^ gf_mul(t[4*c+3], 8'h0d);
                m[4*c+2] = gf_mul(t[4*c], 8'h0d) ^ gf_mul(t[4*c+1], 8'h09)
                         ^ gf_mul(t[4*c+2], 8'h0e) ^ gf_mul(t[4*c+3], 8'h0b);
                m[4*c+3] = gf_mul(t[4*c], 8'h0b) ^ gf_mul(t[4*c+1], 8'h0d)
                         ^ gf_mul(t[4*c+2], 8'h09) ^ gf_mul(t[4*c+3], 8'h0e);
            end
        end
        state_out = m;
    end

endmodule

// File: rtl/aes_128_dec.sv
// ---------------------------------------------------------------------------
// aes_128_dec
// Iterative AES-128 decryptor, one round per clock.
// The cipher key is expanded forward to rk10 in place (KEXP, 10 cycles),
// then the key register is walked back down to rk0 while the rounds run,
// so no key-schedule storage is needed.
// Ports:
//   clk  : clock, rising-edge
//   rst  : asynchronous active-high reset
//   bus  : aes_128_dec_if.slave (in_valid/in_ready/in_bus/key,
//          out_bus/out_valid)
// Latency: 21 cycles accept-edge to out_valid edge, 22 cycles per block.
// ---------------------------------------------------------------------------
module aes_128_dec
    import aes_128_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          rst,
    aes_128_dec_if.slave  bus
);

    localparam logic [3:0] KEXP_LAST  = 4'(NR);
    localparam logic [3:0] ROUND_FIRST = 4'(NR - 1);

    aes_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [127:0] out_bus_q, out_bus_d;
    logic         out_valid_q, out_valid_d;

    logic [127:0] round_out;
    logic         last_round;

    assign last_round = (state_q == FINAL);

    aes_128_inv_round u_inv_round (
        .state_in   (blk_q),
        .round_key  (key_q),
        .last_round (last_round),
        .state_out  (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            blk_q       <= '0;
            key_q       <= '0;
            out_bus_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            out_bus_q   <= out_bus_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state and round counter. The counter counts up 1..10 during key
    // expansion and down 9..1 during the rounds; it is reloaded, never wrapped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = KEXP;
                    cnt_d   = 4'd1;
                end
            end
            KEXP: begin
                if (cnt_q == KEXP_LAST) state_d = ARK0;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            ARK0: begin
                state_d = ROUND;
                cnt_d   = ROUND_FIRST;
            end
            ROUND: begin
                if (cnt_q == 4'd1) state_d = FINAL;
                else               cnt_d   = cnt_q - 4'd1;
            end
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and outputs. The ciphertext waits in blk_q during key
    // expansion; the key register holds rk_r while round r is applied.
    always_comb begin
        blk_d       = blk_q;
        key_d       = key_q;
        out_bus_d   = out_bus_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    blk_d = bus.in_bus;
                    key_d = bus.key;
                end
            end
            KEXP:  key_d = key_fwd(key_q, RCON[cnt_q]);
            ARK0: begin
                blk_d = blk_q ^ key_q;
                key_d = key_inv(key_q, RCON[KEXP_LAST]);
            end
            ROUND: begin
                blk_d = round_out;
                key_d = key_inv(key_q, RCON[cnt_q]);
            end
            FINAL: begin
                out_bus_d   = round_out;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_bus   = out_bus_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_128_dec.sv
// ---------------------------------------------------------------------------
// tb_aes_128_dec
// Directed FIPS-197 vectors from a table, back-to-back and mid-operation
// input scrambling, reset mid-block, and an encrypt/decrypt loopback using
// a bench-side AES-128 encryption model.
// ---------------------------------------------------------------------------
module tb_aes_128_dec;
    import aes_128_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    aes_128_dec_if bus ();

    aes_128_dec #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        bit           scramble;
        bit           hold;
        string        nm;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] tb_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Straightforward FIPS-197 cipher used to produce loopback ciphertexts.
    function automatic logic [127:0] tb_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [127:0] res;
        logic [31:0]  w0, w1, w2, w3, tw;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = k;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            tw = {rk[23:0], rk[31:24]};
            tw = {SBOX[tw[31:24]], SBOX[tw[23:16]], SBOX[tw[15:8]], SBOX[tw[7:0]]};
            w0 = rk[127:96] ^ tw ^ {rc, 24'h0};
            w1 = rk[95:64] ^ w0;
            w2 = rk[63:32] ^ w1;
            w3 = rk[31:0] ^ w2;
            rk = {w0, w1, w2, w3};
            rc = tb_xt(rc);
            for (int i = 0; i < 16; i++) t[i] = SBOX[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row+4*c] = t[row+4*((c+row)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
                    s[4*c+3] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Call just after a falling edge. Presents one request, lets it be
    // accepted on the next rising edge (E0) and follows it to E21.
    // scramble: randomize in_valid/in_bus/key every cycle after E0.
    // hold:     keep in_valid high and return right after E21 so the caller
    //           can observe the back-to-back accept at E22.
    task automatic run_block(input logic [127:0] k, input logic [127:0] ct,
                             input logic [127:0] pt, input bit scramble,
                             input bit hold, input string nm);
        int first_ov;
        bit rdy_low_bad;
        bus.in_valid = 1'b1;
        bus.in_bus   = ct;
        bus.key      = k;
        chk({nm, ".ready_before"}, 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
        first_ov    = -1;
        rdy_low_bad = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            if (scramble) begin
                bus.in_bus   = rnd128();
                bus.key      = rnd128();
                bus.in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            if (bus.out_valid && first_ov < 0) first_ov = c;
            if (c < 21 && bus.in_ready) rdy_low_bad = 1'b1;
        end
        if (scramble) bus.in_valid = 1'b0;
        chk({nm, ".latency"}, 128'(first_ov), 128'(21));
        chk({nm, ".out_bus"}, bus.out_bus, pt);
        chk({nm, ".ready_busy"}, 128'(rdy_low_bad), 128'(0));
        chk({nm, ".ready_at_ov"}, 128'(bus.in_ready), 128'(1));
        if (!hold) begin
            @(posedge clk);
            #1;
            chk({nm, ".ov_pulse"}, 128'(bus.out_valid), 128'(0));
            chk({nm, ".out_hold"}, bus.out_bus, pt);
        end
    endtask

    initial begin
        logic [127:0] lk, lpt;
        total = 0;
        bad   = 0;

        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    scramble: 1'b0, hold: 1'b0, nm: "fips_c1"};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    scramble: 1'b1, hold: 1'b0, nm: "fips_b_scramble"};
        vecs[2] = '{key: 128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    pt:  128'h0,
                    scramble: 1'b0, hold: 1'b1, nm: "zero_first"};
        vecs[3] = '{key: 128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    pt:  128'h0,
                    scramble: 1'b0, hold: 1'b0, nm: "zero_b2b"};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bus   = '0;
        bus.key      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.out_valid", 128'(bus.out_valid), 128'(0));
        chk("reset.out_bus", bus.out_bus, 128'h0);
        chk("reset.in_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            run_block(vecs[v].key, vecs[v].ct, vecs[v].pt, vecs[v].scramble,
                      vecs[v].hold, vecs[v].nm);
        end

        for (int n = 0; n < 1000; n++) begin
            lk  = rnd128();
            lpt = rnd128();
            @(negedge clk);
            run_block(lk, tb_enc(lpt, lk), lpt, 1'b0, 1'b0, "loopback");
            if (bad > 20) break;
        end

        // Abort a block at E15; out_bus still holds the last loopback result.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bus   = vecs[1].ct;
        bus.key      = vecs[1].key;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", 128'(bus.out_valid), 128'(0));
        chk("midrst.out_bus", bus.out_bus, 128'h0);
        chk("midrst.in_ready", 128'(bus.in_ready), 128'(1));
        // in_valid held through deassertion must be taken at the first edge.
        bus.in_valid = 1'b1;
        bus.in_bus   = vecs[0].ct;
        bus.key      = vecs[0].key;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst.out_valid_held", 128'(bus.out_valid), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run_block(vecs[0].key, vecs[0].ct, vecs[0].pt, 1'b0, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
